// File: rtl/branch_ctrl_queue_pkg.sv
// Shared types and helpers for the branch control-flow queue.
// Package name: brq_types. Storage widths follow BRQ_XLEN / BRQ_ROB_IDX_W;
// the top-level XLEN and ROB_IDX_W parameters default to these values.
package brq_types;

  localparam int BRQ_DEPTH     = 8;
  localparam int BRQ_NUM_RES   = 2;
  localparam int BRQ_XLEN      = 32;
  localparam int BRQ_ROB_IDX_W = 5;
  localparam int BRQ_TAG_W     = $clog2(BRQ_DEPTH);

  typedef logic [BRQ_TAG_W-1:0] brq_tag_t;

  typedef struct packed {
    logic                     valid;
    logic                     resolved;
    logic                     mispred;
    logic [BRQ_XLEN-1:0]      pc;
    logic                     pred_taken;
    logic [BRQ_XLEN-1:0]      pred_target;
    logic                     act_taken;
    logic [BRQ_XLEN-1:0]      act_target;
    logic [BRQ_ROB_IDX_W-1:0] rob_id;
  } brq_entry_t;

  // Architecturally correct next PC after a resolved branch.
  function automatic logic [BRQ_XLEN-1:0] brq_next_pc(
    input logic                taken,
    input logic [BRQ_XLEN-1:0] pc,
    input logic [BRQ_XLEN-1:0] target
  );
    return taken ? target : pc + BRQ_XLEN'(4);
  endfunction

endpackage

// File: rtl/branch_ctrl_queue_resolve_cmp.sv
// Per-resolve-port comparator: flags a mispredict when the actual outcome
// differs from the stored prediction (direction, or target when taken).
module brq_resolve_cmp #(
  parameter int XLEN = 32
) (
  input  logic            pred_taken,
  input  logic [XLEN-1:0] pred_target,
  input  logic            act_taken,
  input  logic [XLEN-1:0] act_target,
  output logic            mispred
);

  assign mispred = (act_taken != pred_taken) ||
                   (act_taken && (act_target != pred_target));

endmodule

// File: rtl/branch_ctrl_queue.sv
// In-order control-flow queue: allocates per dispatched control uop, accepts
// out-of-order resolves, retires in order to the predictor update port and
// reports the oldest mispredict to the ROB. Retirement stalls after a
// mispredict until flush.
// Optional feature macro: BRQ_PERF_CNT_EN adds perf_retired / perf_mispred.
module branch_ctrl_queue
  import brq_types::*;
#(
  parameter int DEPTH     = BRQ_DEPTH,
  parameter int NUM_RES   = BRQ_NUM_RES,
  parameter int ROB_IDX_W = BRQ_ROB_IDX_W,
  parameter int XLEN      = BRQ_XLEN,
  localparam int TAG_W    = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 alloc_valid,
  output logic                 alloc_ready,
  input  logic [XLEN-1:0]      alloc_pc,
  input  logic                 alloc_pred_taken,
  input  logic [XLEN-1:0]      alloc_pred_target,
  input  logic [ROB_IDX_W-1:0] alloc_rob_id,
  output logic [TAG_W-1:0]     alloc_tag,
  input  logic                 res_valid  [NUM_RES],
  input  logic [TAG_W-1:0]     res_tag    [NUM_RES],
  input  logic                 res_taken  [NUM_RES],
  input  logic [XLEN-1:0]      res_target [NUM_RES],
  output logic                 bp_upd_valid,
  input  logic                 bp_upd_ready,
  output logic [XLEN-1:0]      bp_upd_pc,
  output logic [XLEN-1:0]      bp_upd_target,
  output logic                 bp_upd_taken,
  output logic                 bp_upd_mispred,
  output logic                 rob_mispred_valid,
  output logic [ROB_IDX_W-1:0] rob_mispred_rob_id,
  output logic [XLEN-1:0]      rob_mispred_target
`ifdef BRQ_PERF_CNT_EN
  ,
  output logic [31:0]          perf_retired,
  output logic [31:0]          perf_mispred
`endif
);

  brq_entry_t         q [DEPTH];
  logic [TAG_W:0]     head, tail;
  logic [TAG_W-1:0]   head_idx, tail_idx;
  logic               empty, full, blocked;
  logic               do_alloc, do_retire;
  logic [NUM_RES-1:0] res_hit, cmp_mispred;
  logic               dup_tag;

  assign head_idx    = head[TAG_W-1:0];
  assign tail_idx    = tail[TAG_W-1:0];
  assign empty       = (head == tail);
  assign full        = (head_idx == tail_idx) && (head[TAG_W] != tail[TAG_W]);
  assign alloc_ready = !full;
  assign alloc_tag   = tail_idx;
  assign do_alloc    = alloc_valid && !full && !flush;
  assign do_retire   = !flush && !empty && !blocked &&
                       q[head_idx].valid && q[head_idx].resolved &&
                       (!bp_upd_valid || bp_upd_ready);

  for (genvar p = 0; p < NUM_RES; p++) begin : g_cmp
    brq_resolve_cmp #(.XLEN(XLEN)) u_cmp (
      .pred_taken  (q[res_tag[p]].pred_taken),
      .pred_target (q[res_tag[p]].pred_target),
      .act_taken   (res_taken[p]),
      .act_target  (res_target[p]),
      .mispred     (cmp_mispred[p])
    );
  end

  // A resolve only lands on a live, still-unresolved entry.
  always_comb begin
    res_hit = '0;
    for (int p = 0; p < NUM_RES; p++)
      res_hit[p] = res_valid[p] && q[res_tag[p]].valid && !q[res_tag[p]].resolved;
  end

  // Detect two ports resolving the same tag in one cycle.
  always_comb begin
    dup_tag = 1'b0;
    for (int i = 0; i < NUM_RES; i++)
      for (int j = i + 1; j < NUM_RES; j++)
        if (res_valid[i] && res_valid[j] && (res_tag[i] == res_tag[j]))
          dup_tag = 1'b1;
  end

  a_no_dup_resolve: assert property (@(posedge clk) disable iff (rst) !dup_tag);

  // Queue storage, pointers, retire output register and mispredict pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) q[i] <= '0;
      head               <= '0;
      tail               <= '0;
      blocked            <= 1'b0;
      bp_upd_valid       <= 1'b0;
      bp_upd_pc          <= '0;
      bp_upd_target      <= '0;
      bp_upd_taken       <= 1'b0;
      bp_upd_mispred     <= 1'b0;
      rob_mispred_valid  <= 1'b0;
      rob_mispred_rob_id <= '0;
      rob_mispred_target <= '0;
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) q[i].valid <= 1'b0;
      head              <= '0;
      tail              <= '0;
      blocked           <= 1'b0;
      bp_upd_valid      <= 1'b0;
      bp_upd_pc         <= '0;
      bp_upd_target     <= '0;
      bp_upd_taken      <= 1'b0;
      bp_upd_mispred    <= 1'b0;
      rob_mispred_valid <= 1'b0;
    end else begin
      rob_mispred_valid <= 1'b0;
      if (do_alloc) begin
        q[tail_idx] <= '{valid: 1'b1, resolved: 1'b0, mispred: 1'b0,
                         pc: alloc_pc, pred_taken: alloc_pred_taken,
                         pred_target: alloc_pred_target, act_taken: 1'b0,
                         act_target: '0, rob_id: alloc_rob_id};
        tail <= tail + 1'b1;
      end
      // Descending order so the lowest-indexed port wins on a tag collision.
      for (int p = NUM_RES - 1; p >= 0; p--) begin
        if (res_hit[p]) begin
          q[res_tag[p]].resolved   <= 1'b1;
          q[res_tag[p]].act_taken  <= res_taken[p];
          q[res_tag[p]].act_target <= res_target[p];
          q[res_tag[p]].mispred    <= cmp_mispred[p];
        end
      end
      if (do_retire) begin
        q[head_idx].valid <= 1'b0;
        head              <= head + 1'b1;
        bp_upd_valid      <= 1'b1;
        bp_upd_pc         <= q[head_idx].pc;
        bp_upd_target     <= q[head_idx].act_target;
        bp_upd_taken      <= q[head_idx].act_taken;
        bp_upd_mispred    <= q[head_idx].mispred;
        if (q[head_idx].mispred) begin
          blocked            <= 1'b1;
          rob_mispred_valid  <= 1'b1;
          rob_mispred_rob_id <= q[head_idx].rob_id;
          rob_mispred_target <= brq_next_pc(q[head_idx].act_taken,
                                            q[head_idx].pc,
                                            q[head_idx].act_target);
        end
      end else if (bp_upd_ready) begin
        bp_upd_valid <= 1'b0;
      end
    end
  end

`ifdef BRQ_PERF_CNT_EN
  // Retire statistics survive flush; only reset clears them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_retired <= '0;
      perf_mispred <= '0;
    end else if (do_retire) begin
      perf_retired <= perf_retired + 32'd1;
      if (q[head_idx].mispred) perf_mispred <= perf_mispred + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_ctrl_queue.sv
// Directed self-checking bench for branch_ctrl_queue (DEPTH=8, NUM_RES=2).
module tb_branch_ctrl_queue;

  localparam int DEPTH     = 8;
  localparam int NUM_RES   = 2;
  localparam int ROB_IDX_W = 5;
  localparam int XLEN      = 32;
  localparam int TAG_W     = 3;

  logic                 clk = 1'b0;
  logic                 rst, flush;
  logic                 alloc_valid, alloc_ready;
  logic [XLEN-1:0]      alloc_pc, alloc_pred_target;
  logic                 alloc_pred_taken;
  logic [ROB_IDX_W-1:0] alloc_rob_id;
  logic [TAG_W-1:0]     alloc_tag;
  logic                 res_valid  [NUM_RES];
  logic [TAG_W-1:0]     res_tag    [NUM_RES];
  logic                 res_taken  [NUM_RES];
  logic [XLEN-1:0]      res_target [NUM_RES];
  logic                 bp_upd_valid, bp_upd_ready, bp_upd_taken, bp_upd_mispred;
  logic [XLEN-1:0]      bp_upd_pc, bp_upd_target;
  logic                 rob_mispred_valid;
  logic [ROB_IDX_W-1:0] rob_mispred_rob_id;
  logic [XLEN-1:0]      rob_mispred_target;
`ifdef BRQ_PERF_CNT_EN
  logic [31:0]          perf_retired, perf_mispred;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  branch_ctrl_queue #(
    .DEPTH(DEPTH), .NUM_RES(NUM_RES), .ROB_IDX_W(ROB_IDX_W), .XLEN(XLEN)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .flush              (flush),
    .alloc_valid        (alloc_valid),
    .alloc_ready        (alloc_ready),
    .alloc_pc           (alloc_pc),
    .alloc_pred_taken   (alloc_pred_taken),
    .alloc_pred_target  (alloc_pred_target),
    .alloc_rob_id       (alloc_rob_id),
    .alloc_tag          (alloc_tag),
    .res_valid          (res_valid),
    .res_tag            (res_tag),
    .res_taken          (res_taken),
    .res_target         (res_target),
    .bp_upd_valid       (bp_upd_valid),
    .bp_upd_ready       (bp_upd_ready),
    .bp_upd_pc          (bp_upd_pc),
    .bp_upd_target      (bp_upd_target),
    .bp_upd_taken       (bp_upd_taken),
    .bp_upd_mispred     (bp_upd_mispred),
    .rob_mispred_valid  (rob_mispred_valid),
    .rob_mispred_rob_id (rob_mispred_rob_id),
    .rob_mispred_target (rob_mispred_target)
`ifdef BRQ_PERF_CNT_EN
    ,
    .perf_retired       (perf_retired),
    .perf_mispred       (perf_mispred)
`endif
  );

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [XLEN-1:0] pc_of(input int i);
    return 32'h0000_0100 + 32'(i) * 32'd4;
  endfunction

  task automatic clr_res();
    for (int p = 0; p < NUM_RES; p++) begin
      res_valid[p]  = 1'b0;
      res_tag[p]    = '0;
      res_taken[p]  = 1'b0;
      res_target[p] = '0;
    end
  endtask

  task automatic resolve(input int p, input int tag, input logic taken, input logic [XLEN-1:0] tgt);
    res_valid[p]  = 1'b1;
    res_tag[p]    = TAG_W'(tag);
    res_taken[p]  = taken;
    res_target[p] = tgt;
  endtask

  task automatic alloc(input int i);
    alloc_valid  = 1'b1;
    alloc_pc     = pc_of(i);
    alloc_rob_id = ROB_IDX_W'(i + 3);
    step();
    alloc_valid  = 1'b0;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; alloc_valid = 1'b0; alloc_pc = '0;
    alloc_pred_taken = 1'b0; alloc_pred_target = '0; alloc_rob_id = '0;
    bp_upd_ready = 1'b1;
    clr_res();
    step(); step();
    chk("rst_alloc_ready", alloc_ready, 1);
    chk("rst_alloc_tag", alloc_tag, 0);
    chk("rst_bp_valid", bp_upd_valid, 0);
    chk("rst_rob_valid", rob_mispred_valid, 0);
    rst = 1'b0;

    // fill all 8 entries
    for (int i = 0; i < DEPTH; i++) begin
      chk("fill_tag", alloc_tag, i);
      chk("fill_ready", alloc_ready, 1);
      alloc(i);
    end
    chk("full_ready", alloc_ready, 0);
    chk("full_tag", alloc_tag, 0);

    // out-of-order resolve: tag2 (port1), tag0 (port0), tag1 (port1)
    resolve(1, 2, 1'b0, '0); step(); clr_res();
    resolve(0, 0, 1'b0, '0); step(); clr_res();
    resolve(1, 1, 1'b0, '0);
    chk("lat_not_yet", bp_upd_valid, 0);
    step(); clr_res();
    chk("upd0_valid", bp_upd_valid, 1);
    chk("upd0_pc", bp_upd_pc, pc_of(0));
    chk("upd0_mispred", bp_upd_mispred, 0);
    chk("free_ready", alloc_ready, 1);
    chk("free_tag", alloc_tag, 0);
    step();
    chk("upd1_pc", bp_upd_pc, pc_of(1));
    step();
    chk("upd2_pc", bp_upd_pc, pc_of(2));
    step();
    chk("upd_idle", bp_upd_valid, 0);

    // backpressure
    bp_upd_ready = 1'b0;
    resolve(0, 3, 1'b0, '0); resolve(1, 4, 1'b0, '0); step(); clr_res();
    step();
    chk("bp_first_valid", bp_upd_valid, 1);
    chk("bp_first_pc", bp_upd_pc, pc_of(3));
    for (int k = 0; k < 5; k++) begin
      step();
      chk("bp_hold_valid", bp_upd_valid, 1);
      chk("bp_hold_pc", bp_upd_pc, pc_of(3));
    end
    bp_upd_ready = 1'b1;
    step();
    chk("bp_rel_valid", bp_upd_valid, 1);
    chk("bp_rel_pc", bp_upd_pc, pc_of(4));
    step();
    chk("bp_rel_idle", bp_upd_valid, 0);

    // flush to empty
    flush = 1'b1; step(); flush = 1'b0;
    chk("flush_tag", alloc_tag, 0);
    chk("flush_ready", alloc_ready, 1);
    chk("flush_bp", bp_upd_valid, 0);

    // mispredict on tag1
    alloc(0); alloc(1); alloc(2);
    resolve(0, 0, 1'b0, '0); resolve(1, 1, 1'b1, 32'h1000); step(); clr_res();
    resolve(0, 2, 1'b0, '0); step(); clr_res();
    chk("mp_upd0_pc", bp_upd_pc, pc_of(0));
    chk("mp_upd0_rob", rob_mispred_valid, 0);
    step();
    chk("mp_upd1_valid", bp_upd_valid, 1);
    chk("mp_upd1_pc", bp_upd_pc, pc_of(1));
    chk("mp_upd1_taken", bp_upd_taken, 1);
    chk("mp_upd1_mispred", bp_upd_mispred, 1);
    chk("mp_upd1_target", bp_upd_target, 32'h1000);
    chk("mp_rob_valid", rob_mispred_valid, 1);
    chk("mp_rob_id", rob_mispred_rob_id, 4);
    chk("mp_rob_target", rob_mispred_target, 32'h1000);
    step();
    chk("mp_rob_pulse_end", rob_mispred_valid, 0);
    chk("mp_blocked0", bp_upd_valid, 0);
    step();
    chk("mp_blocked1", bp_upd_valid, 0);

    // flush together with alloc and resolve
    flush = 1'b1; alloc_valid = 1'b1; alloc_pc = 32'hDEAD0; resolve(0, 2, 1'b1, 32'h40);
    step();
    flush = 1'b0; alloc_valid = 1'b0; clr_res();
    chk("fl_tag", alloc_tag, 0);
    chk("fl_ready", alloc_ready, 1);
    chk("fl_bp", bp_upd_valid, 0);
    chk("fl_rob", rob_mispred_valid, 0);
    step();
    chk("fl_empty", bp_upd_valid, 0);

    // queue usable again after flush
    alloc_valid = 1'b1; alloc_pc = 32'h500; alloc_rob_id = 5'd7; step(); alloc_valid = 1'b0;
    chk("post_fl_tag", alloc_tag, 1);
    resolve(0, 0, 1'b0, '0); step(); clr_res();
    step();
    chk("post_fl_valid", bp_upd_valid, 1);
    chk("post_fl_pc", bp_upd_pc, 32'h500);

    // asynchronous reset mid-stream
    rst = 1'b1; #1;
    chk("arst_bp_valid", bp_upd_valid, 0);
    chk("arst_bp_pc", bp_upd_pc, 0);
    chk("arst_tag", alloc_tag, 0);
    chk("arst_ready", alloc_ready, 1);
    chk("arst_rob", rob_mispred_valid, 0);
    step();
    rst = 1'b0;

`ifdef BRQ_PERF_CNT_EN
    begin
      int tag_m;
      logic mis;
      tag_m = 0;
      chk("perf_rst_ret", perf_retired, 0);
      chk("perf_rst_mis", perf_mispred, 0);
      for (int k = 0; k < 10; k++) begin
        mis = (k % 3 == 2);
        alloc(k);
        resolve(0, tag_m, mis, 32'h2000); step(); clr_res();
        step();
        tag_m = (tag_m + 1) % DEPTH;
        if (mis) begin
          flush = 1'b1; step(); flush = 1'b0;
          tag_m = 0;
        end
      end
      step();
      chk("perf_retired", perf_retired, 10);
      chk("perf_mispred", perf_mispred, 3);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
